// File: rtl/priority_arbiter_8.sv
// priority_arbiter_8: 8-way fixed/round-robin arbiter with registered one-hot grant and hold limit
module priority_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       rr_mode,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_n;
    logic [2:0]    last_idx, last_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    gnt_n, cand;
    logic [2:0]    idx_n, start, p, win;
    logic          valid_n, found, holding, expire;

    // candidate set and descending circular search from the mode-dependent start point
    always_comb begin
        holding = (state == GRANT) && req[gnt_idx];
        expire  = (MAX_HOLD > 0) && (cnt == CW'(MAX_HOLD));
        cand    = req & ~((holding && expire) ? gnt : 8'h00);
        start   = rr_mode ? last_idx - 3'd1 : 3'd7;
        found   = 1'b0;
        win     = 3'd0;
        p       = start;
        for (int i = 0; i < 8; i++) begin
            p = start - 3'(i);
            if (!found && cand[p]) begin
                found = 1'b1;
                win   = p;
            end
        end
    end

    // next-state, next-grant and hold-counter decisions
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        idx_n   = gnt_idx;
        valid_n = gnt_valid;
        cnt_n   = cnt;
        last_n  = last_idx;
        if (holding && !expire) begin
            cnt_n = &cnt ? cnt : cnt + CW'(1);
        end else if (found) begin
            state_n = GRANT;
            gnt_n   = 8'h01 << win;
            idx_n   = win;
            valid_n = 1'b1;
            cnt_n   = CW'(1);
            last_n  = win;
        end else if (holding) begin
            cnt_n = CW'(1);
        end else begin
            state_n = IDLE;
            gnt_n   = 8'h00;
            idx_n   = 3'd0;
            valid_n = 1'b0;
            cnt_n   = '0;
        end
    end

    // state and output registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            cnt       <= '0;
            last_idx  <= 3'd0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            gnt_idx   <= idx_n;
            gnt_valid <= valid_n;
            cnt       <= cnt_n;
            last_idx  <= last_n;
        end
    end

endmodule
